// File: rtl/dual_edge_mealy.sv
// dual_edge_mealy: Mealy dual-edge detector.
// anyEdge is high whenever the monitored level differs from the level that
// was last captured at a rising clk edge, so every change of sig produces an
// event that lasts until the next rising edge absorbs the new level.
//
// Build option: define DUAL_EDGE_SYNC_EN to insert a SYNC_STAGES-deep
// synchronizer in front of the FSM. The output then becomes glitch-free and
// is delayed by the synchronizer depth. With the macro undefined, raw sig
// feeds the FSM and the output directly.
module dual_edge_mealy #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic anyEdge
);

  typedef enum logic {
    ZERO = 1'b0,
    ONE  = 1'b1
  } state_t;

  state_t state_r;
  state_t state_next_s;
  logic   level_s;
  logic   edge_s;

  // A synchronizer shallower than two flops cannot settle metastability.
  generate
    if (SYNC_STAGES < 2) begin : g_depth_check
      $error("dual_edge_mealy: SYNC_STAGES must be at least 2");
    end
  endgenerate

`ifdef DUAL_EDGE_SYNC_EN
  logic [SYNC_STAGES-1:0] sync_r;

  // Shift sig through the synchronizer chain; the chain clears on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], sig};
    end
  end

  assign level_s = sync_r[SYNC_STAGES-1];
`else
  assign level_s = sig;
`endif

  // Remember the level seen at the last rising edge; reset forgets it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ZERO;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next level to store, and the Mealy flag for a mismatch with it.
  always_comb begin
    state_next_s = state_r;
    edge_s       = 1'b0;
    case (state_r)
      ZERO: begin
        if (level_s) begin
          state_next_s = ONE;
          edge_s       = 1'b1;
        end else begin
          state_next_s = ZERO;
          edge_s       = 1'b0;
        end
      end
      ONE: begin
        if (!level_s) begin
          state_next_s = ZERO;
          edge_s       = 1'b1;
        end else begin
          state_next_s = ONE;
          edge_s       = 1'b0;
        end
      end
      default: begin
        state_next_s = ZERO;
        edge_s       = 1'b0;
      end
    endcase
  end

  // Reset masks the flag at once, including a pulse already in progress.
  always_comb begin
    if (reset) begin
      anyEdge = 1'b0;
    end else begin
      anyEdge = edge_s;
    end
  end

endmodule

// File: tb/tb_dual_edge_mealy.sv
// Directed bench for dual_edge_mealy in its default (unsynchronized) build.
// The stored level is observed through the output: with reset low, anyEdge
// equals sig exactly when the stored level is 0.
module tb_dual_edge_mealy;

  logic clk;
  logic reset;
  logic sig;
  logic anyEdge;

  int errors;
  int checks;

  dual_edge_mealy #(.SYNC_STAGES(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .sig     (sig),
    .anyEdge (anyEdge)
  );

  // 10 time-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic expected);
    checks++;
    assert (anyEdge === expected) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, anyEdge, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    sig    = 1'b0;

    // Reset state.
    after_edge();
    after_edge();
    check("reset_idle", 1'b0);

    // Release reset, sig low for three cycles.
    @(negedge clk);
    reset = 1'b0;
    #1 check("release_low", 1'b0);
    after_edge(); check("idle_c1", 1'b0);
    after_edge(); check("idle_c2", 1'b0);
    after_edge(); check("idle_c3", 1'b0);

    // Rising change mid-cycle: immediate pulse, cleared by the next edge.
    @(negedge clk);
    sig = 1'b1;
    #1 check("rise_immediate", 1'b1);
    after_edge(); check("rise_absorbed", 1'b0);
    after_edge(); check("rise_held", 1'b0);

    // Falling change: one more pulse.
    @(negedge clk);
    sig = 1'b0;
    #1 check("fall_immediate", 1'b1);
    after_edge(); check("fall_absorbed", 1'b0);

    // Glitch 0->1->0 between edges: follows combinationally, state stays ZERO.
    @(negedge clk);
    sig = 1'b1;
    #1 check("glitch_high", 1'b1);
    #1 sig = 1'b0;
    #1 check("glitch_back", 1'b0);
    after_edge(); check("glitch_no_pulse", 1'b0);
    @(negedge clk);
    sig = 1'b1;
    #1 check("glitch_state_zero", 1'b1);
    #1 sig = 1'b0;
    #1 check("glitch_probe_off", 1'b0);
    after_edge(); check("glitch_probe_edge", 1'b0);

    // Three toggles between edges ending at 1: state ONE afterwards.
    @(negedge clk);
    sig = 1'b1;
    #1 sig = 1'b0;
    #1 sig = 1'b1;
    #1 check("triple_end_high", 1'b1);
    after_edge(); check("triple_absorbed", 1'b0);
    @(negedge clk);
    sig = 1'b0;
    #1 check("triple_state_one", 1'b1);
    #1 sig = 1'b1;
    #1 check("triple_probe_off", 1'b0);
    after_edge(); check("triple_settled", 1'b0);

    // Reset asserted mid-pulse clears it immediately and stores ZERO.
    @(negedge clk);
    sig = 1'b0;
    #1 check("pulse_before_reset", 1'b1);
    #1 reset = 1'b1;
    #1 check("reset_mid_pulse", 1'b0);
    after_edge(); check("reset_edge_low", 1'b0);

    // sig high while in reset: masked; release exposes the pending change.
    @(negedge clk);
    sig = 1'b1;
    #1 check("reset_sig_high", 1'b0);
    after_edge(); check("reset_sig_high_edge", 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1 check("release_sig_high", 1'b1);
    after_edge(); check("release_absorbed", 1'b0);
    after_edge(); check("release_held", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
